// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter -- writeback arbiter in front of the 64x32 register-file write port.
//
// Merges three writeback sources into one registered write port (we/wa/wd):
//   - ALU : no back-pressure, always wins when alu_valid is high
//   - load: buffered in a QDEPTH-entry FIFO (mem_*)
//   - FPU : buffered in a QDEPTH-entry FIFO (fpu_*)
// When only the two FIFOs compete, a single round-robin bit (rr) alternates
// between them; rr flips only when both were non-empty and the ALU was idle.
// Also keeps a pending-write scoreboard (one bit per register) that the issue
// stage uses to stall on outstanding destinations.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/addr/data           ALU result (must be accepted)
//   mem_valid/ready/addr/data     load result handshake
//   fpu_valid/ready/addr/data     FPU result handshake
//   issue_valid/issue_addr        destination issued this cycle (sets pending)
//   we/wa/wd                      registered register-file write port
//   pending                       bit i set while a write to register i is outstanding
//
// Handshake: a source transfer happens on a cycle where valid && ready at the
// posedge. ready is !full taken from the registered FIFO count, so ready never
// depends combinationally on valid, and a pop only frees a slot in ready on the
// following cycle.
//
// Optional feature: define RF_WB_ZERO_DROP_EN to make register 0 hard-wired.
// A granted entry addressed to register 0 is then consumed without a write
// and pending[0] is held at 0.

module rf_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module rf_wb_arbiter #(
    parameter int QDEPTH = 4,
    parameter int AW     = 6,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_addr,
    input  logic [DW-1:0]        alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_data,
    input  logic                 fpu_valid,
    output logic                 fpu_ready,
    input  logic [AW-1:0]        fpu_addr,
    input  logic [DW-1:0]        fpu_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_addr,
    output logic                 we,
    output logic [AW-1:0]        wa,
    output logic [DW-1:0]        wd,
    output logic [(1<<AW)-1:0]   pending
);
    localparam int EW = AW + DW;

    logic          mem_push, mem_pop, mem_empty, mem_full;
    logic          fpu_push, fpu_pop, fpu_empty, fpu_full;
    logic [EW-1:0] mem_head, fpu_head;

    logic          rr;
    logic          grant_alu, grant_mem, grant_fpu;
    logic          grant_any, contested, drop;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [(1<<AW)-1:0] pending_nxt;

    assign mem_ready = !mem_full;
    assign fpu_ready = !fpu_full;
    assign mem_push  = mem_valid && mem_ready;
    assign fpu_push  = fpu_valid && fpu_ready;
    assign mem_pop   = grant_mem;
    assign fpu_pop   = grant_fpu;

    rf_wb_fifo #(.DEPTH(QDEPTH), .W(EW)) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_push),
        .pop   (mem_pop),
        .din   ({mem_addr, mem_data}),
        .dout  (mem_head),
        .empty (mem_empty),
        .full  (mem_full)
    );

    rf_wb_fifo #(.DEPTH(QDEPTH), .W(EW)) u_fpu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fpu_push),
        .pop   (fpu_pop),
        .din   ({fpu_addr, fpu_data}),
        .dout  (fpu_head),
        .empty (fpu_empty),
        .full  (fpu_full)
    );

    // Fixed priority for the ALU (it cannot be stalled), then round-robin
    // between the two FIFOs, judged only on registered FIFO state.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        grant_fpu = 1'b0;
        if (alu_valid) begin
            grant_alu = 1'b1;
        end else if (!mem_empty && !fpu_empty) begin
            if (rr) begin
                grant_fpu = 1'b1;
            end else begin
                grant_mem = 1'b1;
            end
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
        end else if (!fpu_empty) begin
            grant_fpu = 1'b1;
        end
    end

    assign contested = !alu_valid && !mem_empty && !fpu_empty;
    assign grant_any = grant_alu || grant_mem || grant_fpu;

    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (grant_mem) begin
            sel_addr = mem_head[EW-1:DW];
            sel_data = mem_head[DW-1:0];
        end else if (grant_fpu) begin
            sel_addr = fpu_head[EW-1:DW];
            sel_data = fpu_head[DW-1:0];
        end
    end

`ifdef RF_WB_ZERO_DROP_EN
    assign drop = (sel_addr == '0);
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (contested) begin
            rr <= ~rr;
        end
    end

    // Write port is a one-cycle pulse per grant; wa/wd hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= grant_any && !drop;
            if (grant_any && !drop) begin
                wa <= sel_addr;
                wd <= sel_data;
            end
        end
    end

    // Clear on the write, then set on issue so a same-cycle re-issue of the
    // register keeps it pending for the newer producer.
    always_comb begin
        pending_nxt = pending;
        if (we) begin
            pending_nxt[wa] = 1'b0;
        end
        if (issue_valid) begin
            pending_nxt[issue_addr] = 1'b1;
        end
`ifdef RF_WB_ZERO_DROP_EN
        pending_nxt[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
endmodule
